fsm_cfg_serializer: RTL and testbench

- Transmit end of the serial state-table configuration link.
- Takes a parallel configuration word (jump-table entries plus clock/output select fields) and drives it bit-serially onto the REG_STATE line.
- This line feeds the serial-in/parallel-out loader in front of the look-at-table FSM.
- Before each frame it issues a receiver-reset pulse, so the downstream bit counter starts from zero. It then shifts the frame out and flags completion.

---
 rtl/fsm_cfg_serializer.sv | 114 +++++++++++
 tb/tb_fsm_cfg_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_cfg_serializer.sv
// Serializes a config word onto REG_STATE after an RST_CYCLES rx_rst pulse.
// Frame is RST_CYCLES+WIDTH+1 cycles busy; start is ignored until the IDLE cycle after done.
module fsm_cfg_serializer #(
    parameter int WIDTH      = 27,
    parameter int RST_CYCLES = 2,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             ser_out,
    output logic             rx_rst,
    output logic             busy,
    output logic             done
);

    localparam int MAXV = (WIDTH > RST_CYCLES) ? WIDTH : RST_CYCLES;
    localparam int CW   = (MAXV > 2) ? $clog2(MAXV) : 1;

    typedef enum logic [1:0] {IDLE, PRE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_q, ser_d;
    logic             rx_rst_q, rx_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // The head bit always sits at the same end; the register shifts toward it.
    logic             head_bit;
    logic [WIDTH-1:0] shreg_shifted;

    assign head_bit      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            ser_q    <= 1'b0;
            rx_rst_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            ser_q    <= ser_d;
            rx_rst_q <= rx_rst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        ser_d    = 1'b0;
        rx_rst_d = rx_rst_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                rx_rst_d = 1'b0;
                busy_d   = 1'b0;
                if (start) begin
                    shreg_d  = data_in;
                    busy_d   = 1'b1;
                    rx_rst_d = 1'b1;
                    cnt_d    = CW'(RST_CYCLES - 1);
                    state_d  = PRE;
                end
            end
            PRE: begin
                if (cnt_q == '0) begin
                    rx_rst_d = 1'b0;
                    ser_d    = head_bit;
                    shreg_d  = shreg_shifted;
                    cnt_d    = CW'(WIDTH - 1);
                    state_d  = SHIFT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    ser_d   = head_bit;
                    shreg_d = shreg_shifted;
                    cnt_d   = cnt_q - CW'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ser_out = ser_q;
    assign rx_rst  = rx_rst_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_fsm_cfg_serializer.sv
// Directed bench: default 27-bit MSB-first instance plus an 8-bit LSB-first instance.
module tb_fsm_cfg_serializer;

    logic        clk;
    logic        reset;
    logic        start_a, start_b;
    logic [26:0] data_a;
    logic [7:0]  data_b;
    logic        ser_a, rx_a, busy_a, done_a;
    logic        ser_b, rx_b, busy_b, done_b;

    int vec_cnt = 0;
    int err_cnt = 0;

    fsm_cfg_serializer dut_a (
        .clk     (clk),
        .reset   (reset),
        .start   (start_a),
        .data_in (data_a),
        .ser_out (ser_a),
        .rx_rst  (rx_a),
        .busy    (busy_a),
        .done    (done_a)
    );

    fsm_cfg_serializer #(.WIDTH(8), .RST_CYCLES(2), .MSB_FIRST(1'b0)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .start   (start_b),
        .data_in (data_b),
        .ser_out (ser_b),
        .rx_rst  (rx_b),
        .busy    (busy_b),
        .done    (done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        vec_cnt++;
        if ({rx_a, ser_a, busy_a, done_a, rx_b, ser_b, busy_b, done_b} !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_hold got=%b exp=00000000",
                     {rx_a, ser_a, busy_a, done_a, rx_b, ser_b, busy_b, done_b});
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            vec_cnt++;
            if ({rx_a, ser_a, busy_a, done_a} !== 4'b0000) begin
                err_cnt++;
                $display("FAIL idle_quiet i=%0d got=%b exp=0000", i, {rx_a, ser_a, busy_a, done_a});
            end
        end
    endtask

    task automatic test_single_frame();
        logic [3:0] exp;
        data_a  = 27'h4000001;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            exp = {(c >= 1 && c <= 2), (c == 3 || c == 29), (c <= 30), (c == 30)};
            vec_cnt++;
            if ({rx_a, ser_a, busy_a, done_a} !== exp) begin
                err_cnt++;
                $display("FAIL single c=%0d got=%b exp=%b", c, {rx_a, ser_a, busy_a, done_a}, exp);
            end
            step();
        end
    endtask

    task automatic test_lsb_first();
        int         exp_seq[8] = '{0, 1, 1, 0, 0, 0, 0, 0};
        logic [3:0] exp;
        logic       exp_ser;
        data_b  = 8'b0000_0110;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            exp_ser = (c >= 3 && c <= 10) ? exp_seq[c-3][0] : 1'b0;
            exp = {(c <= 2), exp_ser, (c <= 11), (c == 11)};
            vec_cnt++;
            if ({rx_b, ser_b, busy_b, done_b} !== exp) begin
                err_cnt++;
                $display("FAIL lsb_first c=%0d got=%b exp=%b", c, {rx_b, ser_b, busy_b, done_b}, exp);
            end
            step();
        end
    endtask

    task automatic test_ignore_start();
        logic [26:0] word = '0;
        logic [2:0]  exp;
        data_a  = 27'h5555555;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c >= 3 && c <= 29) word = {word[25:0], ser_a};
            exp = {(c <= 2), (c <= 30), (c == 30)};
            vec_cnt++;
            if ({rx_a, busy_a, done_a} !== exp) begin
                err_cnt++;
                $display("FAIL ignore_ctrl c=%0d got=%b exp=%b", c, {rx_a, busy_a, done_a}, exp);
            end
            if (c == 10 || c == 30) begin
                start_a = 1'b1;
                data_a  = 27'h2AAAAAA;
            end
            if (c == 11 || c == 31) start_a = 1'b0;
            step();
        end
        vec_cnt++;
        if (word !== 27'h5555555) begin
            err_cnt++;
            $display("FAIL ignore_data got=%h exp=5555555", word);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        int         rel;
        data_a  = 27'h7FFFFFF;
        start_a = 1'b1;
        step();
        for (int c = 1; c <= 62; c++) begin
            rel = ((c - 1) % 31) + 1;
            if (rel == 31) exp = 4'b0000;
            else exp = {(rel <= 2), (rel >= 3 && rel <= 29), 1'b1, (rel == 30)};
            vec_cnt++;
            if ({rx_a, ser_a, busy_a, done_a} !== exp) begin
                err_cnt++;
                $display("FAIL b2b c=%0d got=%b exp=%b", c, {rx_a, ser_a, busy_a, done_a}, exp);
            end
            if (c == 62) start_a = 1'b0;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            vec_cnt++;
            if ({rx_a, ser_a, busy_a, done_a} !== 4'b0000) begin
                err_cnt++;
                $display("FAIL b2b_stop i=%0d got=%b exp=0000", i, {rx_a, ser_a, busy_a, done_a});
            end
            step();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [26:0] word = '0;
        logic [3:0]  exp;
        data_a  = 27'h1234567;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (12) step();
        // Cycle 13 carries bit 10 (data bit 16), which is 1 for this word.
        vec_cnt++;
        if ({busy_a, ser_a} !== 2'b11) begin
            err_cnt++;
            $display("FAIL mid_bit10 got=%b exp=11", {busy_a, ser_a});
        end
        reset = 1'b1;
        #1;
        vec_cnt++;
        if ({rx_a, ser_a, busy_a, done_a} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL mid_async got=%b exp=0000", {rx_a, ser_a, busy_a, done_a});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vec_cnt++;
            if ({rx_a, ser_a, busy_a, done_a} !== 4'b0000) begin
                err_cnt++;
                $display("FAIL mid_hold i=%0d got=%b exp=0000", i, {rx_a, ser_a, busy_a, done_a});
            end
        end
        reset = 1'b0;
        step();
        data_a  = 27'h6D2B3C9;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            if (c >= 3 && c <= 29) word = {word[25:0], ser_a};
            exp = {(c <= 2), (c >= 3 && c <= 29) ? ser_a : 1'b0, (c <= 30), (c == 30)};
            vec_cnt++;
            if ({rx_a, ser_a, busy_a, done_a} !== exp) begin
                err_cnt++;
                $display("FAIL refresh c=%0d got=%b exp=%b", c, {rx_a, ser_a, busy_a, done_a}, exp);
            end
            step();
        end
        vec_cnt++;
        if (word !== 27'h6D2B3C9) begin
            err_cnt++;
            $display("FAIL loopback got=%h exp=6D2B3C9", word);
        end
    endtask

    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        data_a  = '0;
        data_b  = '0;
        test_reset();
        test_single_frame();
        test_lsb_first();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
